// File: rtl/knight_rider_sequencer.sv
// Knight Rider LED scan controller: push-button run/stop, tick divider, ping-pong position to LEDR.
// Latency: press visible on 3rd CLK edge; LEDR/POS/DIR registered together. No backpressure (free-running).
// Optional KRS_TRAIL_EN: keeps previous position and lights it as a 2-LED comet tail.
module knight_rider_sequencer #(
    parameter int N_LEDS = 10,
    parameter int DIV    = 5555556,
    parameter int PW     = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              ONOFF_N,
    input  logic              SPEED,
    output logic [N_LEDS-1:0] LEDR,
    output logic [PW-1:0]     POS,
    output logic              DIR,
    output logic              RUN
);
    localparam int CW = $clog2(DIV);

    typedef enum logic [1:0] {OFF, UP, DOWN} state_t;

    state_t            state, state_nxt;
    logic              s1, s2, s3;
    logic              toggle;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     lim_m1;
    logic              tick;
    logic [PW-1:0]     pos_nxt;
    logic              dir_nxt;
    logic [N_LEDS-1:0] ledr_nxt;
`ifdef KRS_TRAIL_EN
    logic [PW-1:0]     prev, prev_nxt;
`endif

    // Two flops resolve metastability, the third gives the falling-edge reference.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= ONOFF_N;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign toggle = s3 & ~s2;
    assign RUN    = (state != OFF);
    assign lim_m1 = SPEED ? CW'(DIV/2 - 1) : CW'(DIV - 1);
    // >= rather than == so a mid-count drop of the limit ticks next cycle.
    assign tick   = RUN && (cnt >= lim_m1);

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            cnt <= '0;
        end else if (!RUN || toggle || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        pos_nxt   = POS;
        dir_nxt   = DIR;
`ifdef KRS_TRAIL_EN
        prev_nxt  = prev;
`endif
        case (state)
            OFF: begin
                pos_nxt = '0;
                dir_nxt = 1'b1;
                if (toggle) state_nxt = UP;
            end
            UP: begin
                if (toggle) begin
                    state_nxt = OFF;
                    pos_nxt   = '0;
                    dir_nxt   = 1'b1;
                end else if (tick) begin
                    if (POS == PW'(N_LEDS - 1)) begin
                        state_nxt = DOWN;
                        pos_nxt   = PW'(N_LEDS - 2);
                        dir_nxt   = 1'b0;
                    end else begin
                        pos_nxt = POS + 1'b1;
                    end
                end
            end
            DOWN: begin
                if (toggle) begin
                    state_nxt = OFF;
                    pos_nxt   = '0;
                    dir_nxt   = 1'b1;
                end else if (tick) begin
                    if (POS == '0) begin
                        state_nxt = UP;
                        pos_nxt   = PW'(1);
                        dir_nxt   = 1'b1;
                    end else begin
                        pos_nxt = POS - 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = OFF;
                pos_nxt   = '0;
                dir_nxt   = 1'b1;
            end
        endcase
`ifdef KRS_TRAIL_EN
        if (state_nxt == OFF || state == OFF) begin
            prev_nxt = '0;
        end else if (tick && !toggle) begin
            prev_nxt = POS;
        end
`endif
        ledr_nxt = '0;
        if (state_nxt != OFF) begin
`ifdef KRS_TRAIL_EN
            ledr_nxt = (N_LEDS'(1) << pos_nxt) | (N_LEDS'(1) << prev_nxt);
`else
            ledr_nxt = N_LEDS'(1) << pos_nxt;
`endif
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state <= OFF;
            POS   <= '0;
            DIR   <= 1'b1;
            LEDR  <= '0;
`ifdef KRS_TRAIL_EN
            prev  <= '0;
`endif
        end else begin
            state <= state_nxt;
            POS   <= pos_nxt;
            DIR   <= dir_nxt;
            LEDR  <= ledr_nxt;
`ifdef KRS_TRAIL_EN
            prev  <= prev_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_knight_rider_sequencer.sv
// Randomized bench for knight_rider_sequencer against a tick-count/phase reference model.
module tb_knight_rider_sequencer;
    localparam int N   = 10;
    localparam int DIV = 4;
    localparam int PW  = 4;

    logic          CLK = 1'b0;
    logic          CLR = 1'b0;
    logic          ONOFF_N = 1'b1;
    logic          SPEED = 1'b0;
    logic [N-1:0]  LEDR;
    logic [PW-1:0] POS;
    logic          DIR;
    logic          RUN;

    int n_vec = 0;
    int n_err = 0;

    knight_rider_sequencer #(.N_LEDS(N), .DIV(DIV), .PW(PW)) dut (
        .CLK(CLK), .CLR(CLR), .ONOFF_N(ONOFF_N), .SPEED(SPEED),
        .LEDR(LEDR), .POS(POS), .DIR(DIR), .RUN(RUN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Model: run flag, number of ticks since start, cycles since last tick, button sample history.
    bit m_run;
    int m_k;
    int m_cnt;
    bit h1, h2, h3;

    always @(posedge CLK or negedge CLR) begin
        bit tog, tk;
        int lim;
        if (!CLR) begin
            m_run = 0; m_k = 0; m_cnt = 0;
            h1 = 1; h2 = 1; h3 = 1;
        end else begin
            tog = (h2 == 0) && (h3 == 1);
            lim = SPEED ? DIV/2 : DIV;
            tk  = m_run && (m_cnt >= lim - 1);
            if (tog) begin
                m_run = !m_run; m_k = 0; m_cnt = 0;
            end else if (m_run) begin
                if (tk) begin m_k++; m_cnt = 0; end
                else m_cnt++;
            end
            h3 = h2; h2 = h1; h1 = ONOFF_N;
        end
    end

    // Position after kk ticks: LED0 at start, then 1..N-1 up, N-2..0 down, repeating.
    function automatic int fpos(int kk);
        int m;
        if (kk == 0) return 0;
        m = (kk - 1) % (2*N - 2);
        if (m < N - 1) return m + 1;
        return (2*N - 3) - m;
    endfunction

    function automatic int fdir(int kk);
        if (kk == 0) return 1;
        return (((kk - 1) % (2*N - 2)) < N - 1) ? 1 : 0;
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] e_led, e_pos, e_dir, e_run;
        e_run = m_run;
        e_pos = m_run ? fpos(m_k) : 0;
        e_dir = m_run ? fdir(m_k) : 1;
        e_led = 0;
        if (m_run) begin
            e_led = 32'd1 << e_pos;
`ifdef KRS_TRAIL_EN
            e_led = e_led | (32'd1 << fpos(m_k > 0 ? m_k - 1 : 0));
`endif
        end
        chk({tag, ".run"}, 32'(RUN), e_run);
        chk({tag, ".pos"}, 32'(POS), e_pos);
        chk({tag, ".dir"}, 32'(DIR), e_dir);
        chk({tag, ".ledr"}, 32'(LEDR), e_led);
    endtask

    initial begin
        // reset state, held after release
        repeat (2) @(negedge CLK);
        check_all("rst");
        CLR = 1'b1;
        repeat (3) begin @(negedge CLK); check_all("idle"); end

        // press: run starts on the 3rd edge with LED0
        ONOFF_N = 1'b0;
        @(negedge CLK); check_all("press1");
        @(negedge CLK); check_all("press2");
        chk("start_not_yet", 32'(RUN), 32'd0);
        @(negedge CLK); check_all("press3");
        chk("start_run", 32'(RUN), 32'd1);
        chk("start_led", 32'(LEDR), 32'h001);
        ONOFF_N = 1'b1;
        // slow scan through both turnarounds
        repeat (160) begin @(negedge CLK); check_all("scan"); end

        // async clear mid-scan
        ONOFF_N = 1'($urandom_range(0, 1));
        CLR = 1'b0;
        #1 check_all("clr_async");
        chk("clr_run", 32'(RUN), 32'd0);
        @(negedge CLK); CLR = 1'b1; ONOFF_N = 1'b1;
        repeat (6) begin @(negedge CLK); check_all("after_clr"); end

        // random presses, bounces, speed changes and clears
        for (int c = 0; c < 8000; c++) begin
            @(negedge CLK);
            check_all("rnd");
            if ($urandom_range(0, 119) == 0) ONOFF_N = ~ONOFF_N;
            if ($urandom_range(0, 29) == 0 && $urandom_range(0, 9) == 0) begin
                ONOFF_N = ~ONOFF_N;
                @(negedge CLK); check_all("bounce");
                ONOFF_N = ~ONOFF_N;
            end
            if ($urandom_range(0, 299) == 0) SPEED = ~SPEED;
            if ($urandom_range(0, 1499) == 0) begin
                CLR = 1'b0;
                #1 check_all("rnd_clr");
                @(negedge CLK); CLR = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
